// File: rtl/snn_axis_frame_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : snn_axis_frame_streamer_if
//  Purpose  : Bundles the capture-side handshake (neuron lanes in) and the
//             AXI-stream result port (one value per beat out) of the SNN
//             frame streamer.
//  Ports    : in_valid/in_ready/in_data    - multi-lane capture beat
//             m_tvalid/m_tready/m_tdata    - result stream handshake + value
//             m_tuser                      - block index of the beat
//             m_tlast                      - last beat of the frame
//  Modports : master - the streamer (accepts capture beats, drives stream)
//             slave  - the environment (drives capture beats, sinks stream)
//  Revision : 1.0 - initial release
// ============================================================================
interface snn_axis_frame_streamer_if #(
    parameter int W     = 16,
    parameter int LANES = 4,
    parameter int UW    = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [W-1:0]         m_tdata;
    logic [UW-1:0]        m_tuser;
    logic                 m_tlast;

    modport master (
        input  in_valid, in_data, m_tready,
        output in_ready, m_tvalid, m_tdata, m_tuser, m_tlast
    );

    modport slave (
        output in_valid, in_data, m_tready,
        input  in_ready, m_tvalid, m_tdata, m_tuser, m_tlast
    );
endinterface
`default_nettype wire

// File: rtl/snn_axis_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : snn_axis_frame_streamer
//  Purpose  : Captures one SNN result frame (T blocks x N neurons, W bits
//             each) LANES values per beat into a register buffer, then drains
//             it over AXI-stream one value per beat. tuser carries the block
//             index, tlast marks the end of the frame.
//  Ports    : aclk          - clock
//             aresetn       - asynchronous active-low reset
//             start         - pulse, begins capture (honoured only in IDLE)
//             flush         - synchronous abort back to IDLE
//             busy          - state != IDLE
//             frame_done    - 1-cycle pulse after the tlast handshake
//             start_ignored - 1-cycle pulse, start seen outside IDLE
//             axis          - capture + stream bundle (master modport)
//  Options  : SNN_STREAMER_TRAILER_EN - appends a trailer beat carrying a
//             wrapping frame sequence count (tuser all ones, tlast on it).
//  Revision : 1.0 - initial release
// ============================================================================
module snn_axis_frame_streamer #(
    parameter int T     = 4,
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int LANES = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic                      flush,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      start_ignored,
    snn_axis_frame_streamer_if.master axis
);
    localparam int c_DEPTH = T * N;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    // One extra code point so the trailer beat can sit at index c_DEPTH.
    localparam int c_PW    = $clog2(c_DEPTH + 1);
    localparam int c_UW    = (T > 1) ? $clog2(T) : 1;

    localparam logic [c_PW-1:0] c_WR_LAST  = c_PW'(c_DEPTH - LANES);
`ifdef SNN_STREAMER_TRAILER_EN
    localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(c_DEPTH);
`else
    localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(c_DEPTH - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_PW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [c_PW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              r_ign, w_ign_nxt;
    logic [W-1:0]      r_buf [c_DEPTH];

    logic              w_cap;
    logic              w_hs;
    logic [c_AW-1:0]   w_rd_idx;
    logic [c_UW-1:0]   w_blk;

    assign w_cap    = (r_state == ST_FILL) && axis.in_valid;
    assign w_hs     = r_valid && axis.m_tready;
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];
    assign w_blk    = c_UW'(r_rd_ptr / c_PW'(N));

    assign axis.in_ready = (r_state == ST_FILL);
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_done;
    assign start_ignored = r_ign;
    assign axis.m_tvalid = r_valid;

    // ------------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_ign_nxt    = 1'b0;

        if (flush) begin
            // Flush overrides everything, including a coincident start or
            // tlast handshake: no start_ignored, no frame_done.
            w_state_nxt  = ST_IDLE;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            w_ign_nxt = start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_cap) begin
                        w_wr_ptr_nxt = r_wr_ptr + c_PW'(LANES);
                        if (r_wr_ptr == c_WR_LAST) begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // tvalid is registered, so it rises one cycle after
                    // entering DRAIN and is held until the final handshake.
                    w_valid_nxt = 1'b1;
                    if (w_hs) begin
                        if (r_rd_ptr == c_LAST_IDX) begin
                            w_state_nxt  = ST_IDLE;
                            w_valid_nxt  = 1'b0;
                            w_done_nxt   = 1'b1;
                            w_wr_ptr_nxt = '0;
                            w_rd_ptr_nxt = '0;
                        end else begin
                            w_rd_ptr_nxt = r_rd_ptr + c_PW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_ign    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
            r_ign    <= w_ign_nxt;
        end
    end

    // Frame buffer: no reset, every entry is rewritten before it is read.
    always_ff @(posedge aclk) begin
        if (w_cap) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[r_wr_ptr[c_AW-1:0] + c_AW'(k)] <= axis.in_data[k*W +: W];
            end
        end
    end

`ifdef SNN_STREAMER_TRAILER_EN
    logic [W-1:0] r_seq;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_seq <= '0;
        end else if (w_done_nxt) begin
            r_seq <= r_seq + W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Stream payload: a pure function of rd_ptr, so it holds while stalled.
    // Forced to zero whenever tvalid is low (keeps reset values defined).
    // ------------------------------------------------------------------------
    always_comb begin
        axis.m_tdata = '0;
        axis.m_tuser = '0;
        axis.m_tlast = 1'b0;
        if (r_valid) begin
            axis.m_tdata = r_buf[w_rd_idx];
            axis.m_tuser = w_blk;
            axis.m_tlast = (r_rd_ptr == c_LAST_IDX);
`ifdef SNN_STREAMER_TRAILER_EN
            if (r_rd_ptr == c_PW'(c_DEPTH)) begin
                axis.m_tdata = r_seq;
                axis.m_tuser = '1;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snn_axis_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_axis_frame_streamer
//  Purpose  : Directed self-checking bench for snn_axis_frame_streamer
//             (T=4, N=16, W=16, LANES=4). Follows SNN_STREAMER_TRAILER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snn_axis_frame_streamer;
    localparam int T     = 4;
    localparam int N     = 16;
    localparam int W     = 16;
    localparam int LANES = 4;
    localparam int UW    = 2;
    localparam int DEPTH = T * N;
    localparam int BEATS = DEPTH / LANES;
`ifdef SNN_STREAMER_TRAILER_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif
    localparam int NB = DEPTH + TR;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic start   = 1'b0;
    logic flush   = 1'b0;
    logic busy, frame_done, start_ignored;

    snn_axis_frame_streamer_if #(.W(W), .LANES(LANES), .UW(UW)) axis ();

    snn_axis_frame_streamer #(.T(T), .N(N), .W(W), .LANES(LANES)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .flush         (flush),
        .busy          (busy),
        .frame_done    (frame_done),
        .start_ignored (start_ignored),
        .axis          (axis)
    );

    always #5 aclk = ~aclk;

    int            checks   = 0;
    int            failures = 0;
    int            si_count = 0;
    int            fd_count = 0;
    int            rx_n;
    int            stall_changes;
    bit            drain_to;
    logic [W-1:0]  exp_seq  = '0;
    logic [W-1:0]  rx_data [NB+4];
    logic [UW-1:0] rx_user [NB+4];
    logic          rx_last [NB+4];

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
        if (start_ignored) si_count++;
        if (frame_done)    fd_count++;
    endtask

    // Start a frame and push nbeats capture beats, value = base + neuron index.
    task automatic capture(input logic [W-1:0] base, input int nbeats, input int start_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            axis.in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                axis.in_data[k*W +: W] = base + W'(i * LANES + k);
            end
            start = (i == start_at);
            tick();
        end
        axis.in_valid = 1'b0;
        start         = 1'b0;
    endtask

    // Sink the stream, recording beats and payload changes during stalls.
    task automatic drain(input bit rand_ready, input int flush_after);
        logic [W+UW:0] held;
        bit            stalled;
        int            cyc;
        held = '0; stalled = 1'b0; cyc = 0;
        rx_n = 0; stall_changes = 0; drain_to = 1'b0;
        forever begin
            if (flush_after >= 0 && rx_n == flush_after) begin
                axis.m_tready = 1'b0;
                flush = 1'b1;
                tick();
                flush = 1'b0;
                return;
            end
            if (cyc >= 4000 || rx_n > NB) begin
                drain_to = 1'b1;
                axis.m_tready = 1'b0;
                return;
            end
            axis.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axis.m_tvalid) begin
                if (stalled && {axis.m_tdata, axis.m_tuser, axis.m_tlast} !== held)
                    stall_changes++;
                held    = {axis.m_tdata, axis.m_tuser, axis.m_tlast};
                stalled = !axis.m_tready;
                if (axis.m_tready) begin
                    rx_data[rx_n] = axis.m_tdata;
                    rx_user[rx_n] = axis.m_tuser;
                    rx_last[rx_n] = axis.m_tlast;
                    rx_n++;
                    if (axis.m_tlast) begin
                        tick();
                        axis.m_tready = 1'b0;
                        return;
                    end
                end
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if ({busy, axis.in_ready, axis.m_tvalid, axis.m_tdata, axis.m_tuser, axis.m_tlast,
             frame_done, start_ignored} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b rdy=%b vld=%b data=%h user=%0d last=%b done=%b ign=%b want all 0",
                     busy, axis.in_ready, axis.m_tvalid, axis.m_tdata, axis.m_tuser, axis.m_tlast,
                     frame_done, start_ignored);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if ({busy, axis.in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_release got busy=%b rdy=%b want 0 0", busy, axis.in_ready);
        end
    endtask

    task automatic test_basic();
        si_count = 0; fd_count = 0;
        capture(16'h0000, BEATS, -1);
        checks++;
        if ({axis.in_ready, busy, axis.m_tvalid} !== 3'b010) begin
            failures++;
            $display("FAIL basic_drain_entry got rdy=%b busy=%b vld=%b want 0 1 0",
                     axis.in_ready, busy, axis.m_tvalid);
        end
        drain(1'b0, -1);
        checks++;
        if (drain_to || rx_n != NB) begin
            failures++;
            $display("FAIL basic_count got beats=%0d timeout=%b want %0d 0", rx_n, drain_to, NB);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            logic [W-1:0]  ed;
            logic [UW-1:0] eu;
            logic          el;
            ed = W'(i); eu = UW'(i / N); el = (i == NB - 1);
            if (i == DEPTH) begin ed = exp_seq; eu = '1; end
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i]} !== {ed, eu, el}) begin
                failures++;
                $display("FAIL basic_beat[%0d] got data=%h user=%0d last=%b want data=%h user=%0d last=%b",
                         i, rx_data[i], rx_user[i], rx_last[i], ed, eu, el);
            end
        end
        checks++;
        if ({axis.m_tvalid, frame_done, busy} !== 3'b010) begin
            failures++;
            $display("FAIL basic_done got vld=%b done=%b busy=%b want 0 1 0",
                     axis.m_tvalid, frame_done, busy);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || fd_count != 1 || si_count != 0) begin
            failures++;
            $display("FAIL basic_pulses got done=%b done_pulses=%0d ign_pulses=%0d want 0 1 0",
                     frame_done, fd_count, si_count);
        end
        exp_seq++;
    endtask

    task automatic test_backpressure();
        fd_count = 0;
        capture(16'h1000, BEATS, -1);
        drain(1'b1, -1);
        checks++;
        if (drain_to || rx_n != NB || stall_changes != 0) begin
            failures++;
            $display("FAIL bp_count got beats=%0d timeout=%b stall_changes=%0d want %0d 0 0",
                     rx_n, drain_to, stall_changes, NB);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            logic [W-1:0]  ed;
            logic [UW-1:0] eu;
            logic          el;
            ed = 16'h1000 + W'(i); eu = UW'(i / N); el = (i == NB - 1);
            if (i == DEPTH) begin ed = exp_seq; eu = '1; end
            checks++;
            if ({rx_data[i], rx_user[i], rx_last[i]} !== {ed, eu, el}) begin
                failures++;
                $display("FAIL bp_beat[%0d] got data=%h user=%0d last=%b want data=%h user=%0d last=%b",
                         i, rx_data[i], rx_user[i], rx_last[i], ed, eu, el);
            end
        end
        tick();
        checks++;
        if (fd_count != 1) begin
            failures++;
            $display("FAIL bp_done got done_pulses=%0d want 1", fd_count);
        end
        exp_seq++;
    endtask

    task automatic test_start_busy();
        si_count = 0; fd_count = 0;
        capture(16'h2000, BEATS, 5);
        start = 1'b1;
        axis.m_tready = 1'b0;
        tick();
        start = 1'b0;
        drain(1'b0, -1);
        tick();
        checks++;
        if (si_count != 2 || fd_count != 1 || rx_n != NB || drain_to) begin
            failures++;
            $display("FAIL busy_start got ign_pulses=%0d done_pulses=%0d beats=%0d timeout=%b want 2 1 %0d 0",
                     si_count, fd_count, rx_n, drain_to, NB);
        end
        for (int i = 0; i < DEPTH && i < rx_n; i++) begin
            checks++;
            if (rx_data[i] !== 16'h2000 + W'(i)) begin
                failures++;
                $display("FAIL busy_beat[%0d] got data=%h want %h", i, rx_data[i], 16'h2000 + W'(i));
            end
        end
        exp_seq++;
    endtask

    task automatic test_flush();
        int nlast;
        fd_count = 0;
        capture(16'h3000, BEATS, -1);
        drain(1'b0, 21);
        checks++;
        if ({axis.m_tvalid, busy, axis.in_ready} !== 3'b000 || rx_n != 21) begin
            failures++;
            $display("FAIL flush_stop got vld=%b busy=%b rdy=%b beats=%0d want 0 0 0 21",
                     axis.m_tvalid, busy, axis.in_ready, rx_n);
        end
        nlast = 0;
        for (int i = 0; i < rx_n && i < NB; i++) begin
            if (rx_last[i]) nlast++;
            checks++;
            if (rx_data[i] !== 16'h3000 + W'(i)) begin
                failures++;
                $display("FAIL flush_beat[%0d] got data=%h want %h", i, rx_data[i], 16'h3000 + W'(i));
            end
        end
        repeat (3) tick();
        checks++;
        if (nlast != 0 || fd_count != 0) begin
            failures++;
            $display("FAIL flush_no_done got tlasts=%0d done_pulses=%0d want 0 0", nlast, fd_count);
        end
        // flush together with start: flush wins, no start_ignored.
        si_count = 0;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || si_count != 0) begin
            failures++;
            $display("FAIL flush_start got busy=%b ign_pulses=%0d want 0 0", busy, si_count);
        end
        capture(16'h4000, BEATS, -1);
        drain(1'b0, -1);
        checks++;
        if (drain_to || rx_n != NB) begin
            failures++;
            $display("FAIL flush_next_count got beats=%0d timeout=%b want %0d 0", rx_n, drain_to, NB);
        end
        for (int i = 0; i < DEPTH && i < rx_n; i++) begin
            checks++;
            if ({rx_data[i], rx_user[i]} !== {16'h4000 + W'(i), UW'(i / N)}) begin
                failures++;
                $display("FAIL flush_next_beat[%0d] got data=%h user=%0d want %h %0d",
                         i, rx_data[i], rx_user[i], 16'h4000 + W'(i), i / N);
            end
        end
        tick();
        exp_seq++;
    endtask

    task automatic test_async_reset();
        capture(16'h5000, 7, -1);
        checks++;
        if ({busy, axis.in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL areset_pre got busy=%b rdy=%b want 1 1", busy, axis.in_ready);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, axis.in_ready, axis.m_tvalid, axis.m_tdata, axis.m_tuser, axis.m_tlast,
             frame_done, start_ignored} !== '0) begin
            failures++;
            $display("FAIL areset_outputs got busy=%b rdy=%b vld=%b data=%h user=%0d last=%b done=%b ign=%b want all 0",
                     busy, axis.in_ready, axis.m_tvalid, axis.m_tdata, axis.m_tuser, axis.m_tlast,
                     frame_done, start_ignored);
        end
        #3 aresetn = 1'b1;
        exp_seq = '0;
        tick();
        capture(16'h6000, BEATS, -1);
        drain(1'b0, -1);
        checks++;
        if (drain_to || rx_n != NB) begin
            failures++;
            $display("FAIL areset_next_count got beats=%0d timeout=%b want %0d 0", rx_n, drain_to, NB);
        end
        for (int i = 0; i < DEPTH && i < rx_n; i++) begin
            checks++;
            if ({rx_data[i], rx_user[i]} !== {16'h6000 + W'(i), UW'(i / N)}) begin
                failures++;
                $display("FAIL areset_beat[%0d] got data=%h user=%0d want %h %0d",
                         i, rx_data[i], rx_user[i], 16'h6000 + W'(i), i / N);
            end
        end
        tick();
        exp_seq++;
    endtask

`ifdef SNN_STREAMER_TRAILER_EN
    task automatic test_trailer();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            capture(16'h7000 + W'(f * 16'h100), BEATS, -1);
            drain(1'b0, -1);
            checks++;
            if (drain_to || rx_n != DEPTH + 1) begin
                failures++;
                $display("FAIL trailer_count[%0d] got beats=%0d timeout=%b want %0d 0",
                         f, rx_n, drain_to, DEPTH + 1);
            end
            checks++;
            if ({rx_data[DEPTH], rx_user[DEPTH], rx_last[DEPTH], rx_last[DEPTH-1]}
                    !== {W'(f), 2'b11, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL trailer_beat[%0d] got data=%h user=%0d last=%b prev_last=%b want %h 3 1 0",
                         f, rx_data[DEPTH], rx_user[DEPTH], rx_last[DEPTH], rx_last[DEPTH-1], f);
            end
        end
    endtask
`endif

    initial begin
        axis.in_valid = 1'b0;
        axis.in_data  = '0;
        axis.m_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_busy();
        test_flush();
        test_async_reset();
`ifdef SNN_STREAMER_TRAILER_EN
        test_trailer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end
endmodule
`default_nettype wire
